wb_regfile_slave: RTL and testbench

WB_REGFILE_SLAVE -- requirements
Module: wb_regfile_slave

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_byte_reg.sv | 45 ++++
 rtl/wb_regfile_slave.sv | 175 +++++++++++++++++
 tb/tb_wb_regfile_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared Wishbone constants and helpers: legal data-width range,
//             ack-latency bounds and the byte-lane count of a data bus.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int c_wb_dw_min  = 8;
  localparam int c_wb_dw_max  = 64;
  localparam int c_wb_lat_min = 1;
  localparam int c_wb_lat_max = 4;

  // Number of byte lanes (select bits) on a DW-bit data bus.
  function automatic int wb_byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_byte_reg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_byte_reg
//  Purpose  : One DW-bit register with per-byte write enables and a
//             parameterised reset value.
//  Ports    : i_clk      - clock
//             i_reset_n  - synchronous active-low reset (loads RST_VAL)
//             i_we       - write enable for this register
//             i_sel      - byte-lane enables, one per byte of i_wdata
//             i_wdata    - write data
//             o_q        - current register contents
//  Revision : 1.0 - initial release
// ============================================================================
module wb_byte_reg import wb_pkg::*; #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_we,
  input  logic [wb_byte_lanes(DW)-1:0] i_sel,
  input  logic [DW-1:0]                i_wdata,
  output logic [DW-1:0]                o_q
);

  localparam int c_lanes = wb_byte_lanes(DW);

  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_q <= RST_VAL;
    end else if (i_we) begin
      for (int b = 0; b < c_lanes; b++) begin
        if (i_sel[b]) begin
          r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/wb_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_slave
//  Purpose  : Pipelined Wishbone slave exposing NREGS byte-writable
//             registers, with optional read-only registers, fixed ack
//             latency LAT and a flat view of all register contents.
//  Ports    : i_clk, i_reset_n         - clock, synchronous active-low reset
//             i_wb_cyc/stb/we/addr/sel - Wishbone request
//             i_wb_idata               - write data
//             o_wb_ack/err/stall       - Wishbone response / flow control
//             o_wb_odata               - read data (zero unless read ack)
//             o_regs                   - register n at [n*DW +: DW]
//             o_wr_strobe              - one-cycle pulse per register written
//  Config   : define WB_REGFILE_ERR_EN to complete out-of-range accesses
//             with o_wb_err; otherwise they complete with ack (reads give 0)
//             and o_wb_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_slave import wb_pkg::*; #(
  parameter int                  DW      = 32,
  parameter int                  AW      = 4,
  parameter int                  NREGS   = 16,
  parameter int                  LAT     = 1,
  parameter logic [NREGS-1:0]    RO_MASK = '0,
  parameter logic [NREGS*DW-1:0] RST_VAL = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [AW-1:0]                i_wb_addr,
  input  logic [wb_byte_lanes(DW)-1:0] i_wb_sel,
  input  logic [DW-1:0]                i_wb_idata,
  output logic                         o_wb_ack,
  output logic                         o_wb_stall,
  output logic                         o_wb_err,
  output logic [DW-1:0]                o_wb_odata,
  output logic [NREGS*DW-1:0]          o_regs,
  output logic [NREGS-1:0]             o_wr_strobe
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (DW < c_wb_dw_min || DW > c_wb_dw_max || (DW % 8) != 0) begin : g_bad_dw
    $error("wb_regfile_slave: DW must be a multiple of 8 in 8..64");
  end
  if (LAT < c_wb_lat_min || LAT > c_wb_lat_max) begin : g_bad_lat
    $error("wb_regfile_slave: LAT must be in 1..4");
  end
  if (NREGS < 1 || NREGS > (1 << AW)) begin : g_bad_nregs
    $error("wb_regfile_slave: NREGS must be in 1..2**AW");
  end

  // --------------------------------------------------------------------------
  // Request acceptance
  // --------------------------------------------------------------------------
  logic             r_stall;
  logic             w_accept;
  logic             w_err_in;
  logic [NREGS-1:0] w_addr_hit;
  logic [DW-1:0]    w_rdata;

  // r_stall is set throughout reset, so it still reads 1 in the first cycle
  // after release; the combinational term covers the cycle reset first drops.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_stall <= 1'b1;
    else            r_stall <= 1'b0;
  end

  assign o_wb_stall = !i_reset_n || r_stall;
  assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;

`ifdef WB_REGFILE_ERR_EN
  logic [AW:0] w_addr_ext;
  assign w_addr_ext = {1'b0, i_wb_addr};
  assign w_err_in   = (w_addr_ext >= (AW+1)'(NREGS));
`else
  assign w_err_in   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Register array. An out-of-range address hits no register, so writes to
  // it are dropped and it raises no strobe.
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < NREGS; n++) begin : g_regs
    logic w_reg_we;

    assign w_addr_hit[n] = (i_wb_addr == AW'(n));
    assign w_reg_we      = w_accept && i_wb_we && w_addr_hit[n] && !RO_MASK[n];

    wb_byte_reg #(
      .DW      (DW),
      .RST_VAL (RST_VAL[n*DW +: DW])
    ) u_reg (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we      (w_reg_we),
      .i_sel     (i_wb_sel),
      .i_wdata   (i_wb_idata),
      .o_q       (o_regs[n*DW +: DW])
    );
  end

  // Read data is taken from the pre-edge register value; writes and
  // out-of-range reads carry zero down the pipeline.
  always_comb begin
    w_rdata = '0;
    if (w_accept && !i_wb_we) begin
      for (int n = 0; n < NREGS; n++) begin
        if (w_addr_hit[n]) begin
          w_rdata = o_regs[n*DW +: DW];
        end
      end
    end
  end

  logic [NREGS-1:0] r_wr_strobe;

  // Strobes fire for any accepted write to an implemented register, even
  // with sel=0 or a read-only target.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= (w_accept && i_wb_we) ? w_addr_hit : '0;
    end
  end

  assign o_wr_strobe = r_wr_strobe;

  // --------------------------------------------------------------------------
  // Response pipeline: LAT stages of valid / error / data.
  // Dropping i_wb_cyc clears every stage so in-flight requests never answer.
  // --------------------------------------------------------------------------
  logic          r_pv [LAT];
  logic          r_pe [LAT];
  logic [DW-1:0] r_pd [LAT];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_wb_cyc) begin
      for (int i = 0; i < LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pe[0] <= w_accept && w_err_in;
      r_pd[0] <= w_rdata;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Gating with i_wb_cyc and i_reset_n suppresses a response that is already
  // at the last stage in the very cycle the bus is abandoned or reset.
  logic w_resp_live;
  assign w_resp_live = r_pv[LAT-1] && i_wb_cyc && i_reset_n;

  assign o_wb_ack   = w_resp_live && !r_pe[LAT-1];
  assign o_wb_odata = o_wb_ack ? r_pd[LAT-1] : '0;

`ifdef WB_REGFILE_ERR_EN
  assign o_wb_err = w_resp_live && r_pe[LAT-1];
`else
  assign o_wb_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile_slave
//  Purpose  : Directed self-checking bench. Three slaves share one bus:
//             u1 (LAT=1, 16 regs, reg2 read-only), u2 (LAT=2, 16 regs) and
//             u3 (LAT=3, 10 regs). Expected values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_slave;

  localparam logic [511:0] RV1 = (512'h1234_5678 << 64) | (512'hCAFE_0005 << 160);
  localparam logic [319:0] RV3 = {224'h0, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  addr;
  logic [3:0]  sel;
  logic [31:0] idata;

  logic         ack1, stall1, err1;
  logic [31:0]  odata1;
  logic [511:0] regs1;
  logic [15:0]  strb1;

  logic         ack2, stall2, err2;
  logic [31:0]  odata2;
  logic [511:0] regs2;
  logic [15:0]  strb2;

  logic         ack3, stall3, err3;
  logic [31:0]  odata3;
  logic [319:0] regs3;
  logic [9:0]   strb3;

  always #5 clk = ~clk;

  wb_regfile_slave #(
    .DW(32), .AW(4), .NREGS(16), .LAT(1), .RO_MASK(16'h0004), .RST_VAL(RV1)
  ) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_sel(sel), .i_wb_idata(idata),
    .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_err(err1),
    .o_wb_odata(odata1), .o_regs(regs1), .o_wr_strobe(strb1)
  );

  wb_regfile_slave #(
    .DW(32), .AW(4), .NREGS(16), .LAT(2), .RO_MASK(16'h0000), .RST_VAL(512'h0)
  ) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_sel(sel), .i_wb_idata(idata),
    .o_wb_ack(ack2), .o_wb_stall(stall2), .o_wb_err(err2),
    .o_wb_odata(odata2), .o_regs(regs2), .o_wr_strobe(strb2)
  );

  wb_regfile_slave #(
    .DW(32), .AW(4), .NREGS(10), .LAT(3), .RO_MASK(10'h000), .RST_VAL(RV3)
  ) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_sel(sel), .i_wb_idata(idata),
    .o_wb_ack(ack3), .o_wb_stall(stall3), .o_wb_err(err3),
    .o_wb_odata(odata3), .o_regs(regs3), .o_wr_strobe(strb3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; sel = '0; idata = '0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check_eq("rst_stall", stall1, 1);
    check_eq("rst_ack",   ack1, 0);
    check_eq("rst_err",   err1, 0);
    check_eq("rst_strb",  strb1, 0);
    check_eq("rst_regs1", regs1, RV1);
    check_eq("rst_regs3", regs3, RV3);
    rst_n = 1'b1;
    #1;
    check_eq("stall_first_cycle", stall1, 1);
    tick();
    check_eq("stall_released1", stall1, 0);
    check_eq("stall_released3", stall3, 0);

    // ---------------- back-to-back reads, LAT=3 on u3 ----------------
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 4'd0;
    tick();
    check_eq("rd3_not_early", ack3, 0);
    check_eq("rd1_ack",       ack1, 1);
    check_eq("rd1_data0",     odata1, 0);
    addr = 4'd1;
    tick();
    addr = 4'd2;
    tick();
    check_eq("rd1_data2",  odata1, 32'h1234_5678);
    check_eq("rd3_ack_a",  ack3, 1);
    check_eq("rd3_data_a", odata3, 32'hA0A0_A0A0);
    stb = 1'b0;
    tick();
    check_eq("rd3_ack_b",  ack3, 1);
    check_eq("rd3_data_b", odata3, 32'hB1B1_B1B1);
    tick();
    check_eq("rd3_ack_c",  ack3, 1);
    check_eq("rd3_data_c", odata3, 32'hC2C2_C2C2);
    tick();
    check_eq("rd3_done",      ack3, 0);
    check_eq("rd3_odata_idle", odata3, 0);

    // ---------------- byte-masked write, LAT=1 on u1 ----------------
    stb = 1'b1; we = 1'b1; addr = 4'd3; sel = 4'b0101; idata = 32'hAABB_CCDD;
    tick();
    check_eq("wr_ack",      ack1, 1);
    check_eq("wr_odata0",   odata1, 0);
    check_eq("wr_reg3",     regs1[3*32 +: 32], 32'h00BB_00DD);
    check_eq("wr_strb",     strb1, 16'h0008);
    stb = 1'b0; we = 1'b0;
    tick();
    check_eq("wr_strb_once", strb1, 0);
    check_eq("wr_ack_once",  ack1, 0);

    // ---------------- read-only target, then sel=0 write ----------------
    stb = 1'b1; we = 1'b1; addr = 4'd2; sel = 4'hF; idata = 32'hFFFF_FFFF;
    tick();
    check_eq("ro_ack",  ack1, 1);
    check_eq("ro_keep", regs1[2*32 +: 32], 32'h1234_5678);
    check_eq("ro_strb", strb1, 16'h0004);
    addr = 4'd5; sel = 4'h0;
    tick();
    check_eq("sel0_ack",  ack1, 1);
    check_eq("sel0_keep", regs1[5*32 +: 32], 32'hCAFE_0005);
    check_eq("sel0_strb", strb1, 16'h0020);
    stb = 1'b0; we = 1'b0;
    repeat (3) tick();

    // ---------------- out of range on u3 (NREGS=10) ----------------
    stb = 1'b1; we = 1'b0; addr = 4'd12;
    tick();
    stb = 1'b0;
    tick();
    check_eq("oor_not_early_ack", ack3, 0);
    check_eq("oor_not_early_err", err3, 0);
    tick();
`ifdef WB_REGFILE_ERR_EN
    check_eq("oor_err",   err3, 1);
    check_eq("oor_noack", ack3, 0);
`else
    check_eq("oor_ack",   ack3, 1);
    check_eq("oor_noerr", err3, 0);
    check_eq("oor_data",  odata3, 0);
`endif
    tick();
    check_eq("oor_single_ack", ack3, 0);
    check_eq("oor_single_err", err3, 0);

    stb = 1'b1; we = 1'b1; addr = 4'd12; sel = 4'hF; idata = 32'h1234_5678;
    tick();
    check_eq("oor_wr_strb", strb3, 0);
    stb = 1'b0; we = 1'b0;
    repeat (3) tick();
    // u3 saw the writes above: reg3 byte-masked, reg2 fully written.
    check_eq("u3_regs_model", regs3,
             {224'h0, 32'hFFFF_FFFF, 32'hB1B1_B1B1, 32'hA0A0_A0A0} | (320'h00BB_00DD << 96));

    // ---------------- abort on u2 (LAT=2) ----------------
    stb = 1'b1; we = 1'b0; addr = 4'd3;
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    check_eq("abort_ack_a", ack2, 0);
    tick();
    check_eq("abort_ack_b", ack2, 0);
    check_eq("abort_err_b", err2, 0);
    cyc = 1'b1;
    #1;
    check_eq("abort_after_cyc", ack2, 0);
    tick();
    check_eq("abort_ack_c", ack2, 0);
    check_eq("abort_err_c", err2, 0);

    // ---------------- reset with two reads in flight on u3 ----------------
    stb = 1'b1; we = 1'b0; addr = 4'd0;
    tick();
    addr = 4'd1;
    tick();
    stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstf_ack_a", ack3, 0);
    tick();
    check_eq("rstf_ack_b",   ack3, 0);
    check_eq("rstf_stall_b", stall3, 1);
    tick();
    check_eq("rstf_ack_c", ack3, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rstf_stall_first", stall3, 1);
    check_eq("rstf_ack_d",       ack3, 0);
    tick();
    check_eq("rstf_stall_off", stall3, 0);
    check_eq("rstf_ack_e",     ack3, 0);
    tick();
    check_eq("rstf_ack_f",  ack3, 0);
    check_eq("rstf_err_f",  err3, 0);
    check_eq("rstf_regs3",  regs3, RV3);
    check_eq("rstf_regs1",  regs1, RV1);
    check_eq("rstf_strb1",  strb1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
